// File: rtl/debounce_pkg.sv
// debounce_pkg: default configuration and counter-width helpers shared by the debouncer files.
package debounce_pkg;
  localparam int NCH_DEF        = 4;
  localparam int SAMPLE_DIV_DEF = 100000;
  localparam int STABLE_CNT_DEF = 8;
  localparam int LONG_TICKS_DEF = 50;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DIV_W_DEF  = cnt_w(SAMPLE_DIV_DEF - 1);
  localparam int STB_W_DEF  = cnt_w(STABLE_CNT_DEF);
  localparam int LONG_W_DEF = cnt_w(LONG_TICKS_DEF);
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel: synchronizer, tick-sampled qualification, edge pulses.
// The long-press detector is built only when BTN_LONG_PRESS_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef BTN_LONG_PRESS_EN
  ,
  parameter int LONG_TICKS = LONG_TICKS_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);
  localparam int STB_W = cnt_w(STABLE_CNT);

  logic [1:0]       r_sync;
  logic [STB_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = r_sync[1] ^ r_level;
  // Toggle on the tick that would bring the disagreement count to STABLE_CNT.
  assign w_flip = i_tick & w_diff & (r_cnt == STB_W'(STABLE_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_rise <= w_flip & ~r_level;
      r_fall <= w_flip & r_level;
      if (w_flip) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (i_tick) begin
        r_cnt <= w_diff ? r_cnt + 1'b1 : '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_W = cnt_w(LONG_TICKS);

  logic [LONG_W-1:0] r_lcnt;
  logic              r_long;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= i_tick & r_level & (r_lcnt == LONG_W'(LONG_TICKS - 1));
      if (!r_level)
        r_lcnt <= '0;
      else if (i_tick && r_lcnt != LONG_W'(LONG_TICKS))
        r_lcnt <= r_lcnt + 1'b1;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: NCH independent button debouncers sharing one sample-tick divider.
// Define BTN_LONG_PRESS_EN to enable the per-channel long-press pulse on btn_long.
module btn_debounce_multi
  import debounce_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] btn_in,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_rise,
  output logic [NCH-1:0] btn_fall,
  output logic [NCH-1:0] btn_long
);
  localparam int DIV_W = cnt_w(SAMPLE_DIV - 1);

  if (NCH < 1 || NCH > 32 || SAMPLE_DIV < 1 || STABLE_CNT < 1 || STABLE_CNT > 255 || LONG_TICKS < 1) begin : g_bad_cfg
    $error("btn_debounce_multi: illegal parameter combination");
  end

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_div <= '0;
    else
      r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
`ifdef BTN_LONG_PRESS_EN
      ,
      .LONG_TICKS(LONG_TICKS)
`endif
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_tick (w_tick),
      .i_btn  (btn_in[i]),
      .o_level(btn_level[i]),
      .o_rise (btn_rise[i]),
      .o_fall (btn_fall[i]),
      .o_long (btn_long[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed checks of btn_debounce_multi (NCH=4, SAMPLE_DIV=4, STABLE_CNT=3, LONG_TICKS=5).
module tb_btn_debounce_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'hF;
  logic [3:0] btn_level, btn_rise, btn_fall, btn_long;
  int         n_chk = 0;
  int         n_fail = 0;
  int         rc[4], fc[4], lc[4];
  int         lat;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .NCH(4), .SAMPLE_DIV(4), .STABLE_CNT(3), .LONG_TICKS(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .btn_long (btn_long)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        rc[i] += btn_rise[i] ? 1 : 0;
        fc[i] += btn_fall[i] ? 1 : 0;
        lc[i] += btn_long[i] ? 1 : 0;
      end
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      rc[i] = 0;
      fc[i] = 0;
      lc[i] = 0;
    end
  endtask

  task automatic wait_lvl(input int ch, input logic v, output int n);
    n = 0;
    while (btn_level[ch] !== v && n < 30) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    clr();
    // Reset with all inputs high: every output held at zero.
    step(3);
    chk("rst_level", btn_level, 4'h0);
    chk("rst_rise", btn_rise, 4'h0);
    chk("rst_fall", btn_fall, 4'h0);
    chk("rst_long", btn_long, 4'h0);
    rst_n = 1'b1;
    step(11);
    chk("post_rst_hold", btn_level, 4'h0);
    step(1);
    chk("post_rst_level", btn_level, 4'hF);
    chk("post_rst_rise", btn_rise, 4'hF);
    step(1);
    chk("post_rst_rise_1cyc", btn_rise, 4'h0);
    btn_in = 4'h0;
    step(20);
    chk("all_low", btn_level, 4'h0);
    chk("all_fall_cnt", fc[0] + fc[1] + fc[2] + fc[3], 4);

    // Single channel press and release.
    clr();
    btn_in = 4'h1;
    wait_lvl(0, 1'b1, lat);
    chk("rise_latency_ok", (lat >= 10 && lat <= 14), 1);
    chk("rise_pulse", btn_rise, 4'h1);
    step(1);
    chk("rise_clear", btn_rise, 4'h0);
    step(5);
    chk("rise_once", rc[0], 1);
    btn_in = 4'h0;
    wait_lvl(0, 1'b0, lat);
    chk("fall_latency_ok", (lat >= 10 && lat <= 14), 1);
    chk("fall_pulse", btn_fall, 4'h1);
    step(1);
    chk("fall_clear", btn_fall, 4'h0);
    step(5);
    chk("fall_once", fc[0], 1);

    // Two-tick glitch on channel 1 is noise.
    clr();
    btn_in = 4'h2;
    step(8);
    btn_in = 4'h0;
    step(20);
    chk("glitch_level", btn_level[1], 0);
    chk("glitch_rise", rc[1], 0);
    chk("glitch_fall", fc[1], 0);

    // Simultaneous channels pulse together.
    clr();
    btn_in = 4'hC;
    wait_lvl(2, 1'b1, lat);
    chk("pair_rise", btn_rise, 4'hC);
    step(2);
    chk("pair_level", btn_level, 4'hC);
    chk("pair_rise_cnt", rc[2] + rc[3], 2);
    btn_in = 4'h0;
    step(20);
    chk("pair_low", btn_level, 4'h0);

    // Reset after two qualifying ticks forces full requalification.
    clr();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    btn_in = 4'h1;
    step(9);
    rst_n = 1'b0;
    step(2);
    chk("mid_rst_level", btn_level, 4'h0);
    rst_n = 1'b1;
    step(11);
    chk("requal_hold", btn_level, 4'h0);
    chk("requal_no_pulse", rc[0], 0);
    step(1);
    chk("requal_level", btn_level, 4'h1);
    chk("requal_rise", btn_rise, 4'h1);

`ifdef BTN_LONG_PRESS_EN
    step(19);
    chk("long_early", btn_long, 4'h0);
    chk("long_none_yet", lc[0], 0);
    step(1);
    chk("long_pulse", btn_long, 4'h1);
    step(40);
    chk("long_once", lc[0], 1);
`else
    step(60);
    chk("no_long_cnt", lc[0] + lc[1] + lc[2] + lc[3], 0);
    chk("no_long", btn_long, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
